// File: rtl/rom_fetch_if.sv
// ROM / decoder / redirect bundle for rom_fetch.
// master = fetch unit side, slave = ROM + decoder + controller side.
interface rom_fetch_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] rom_data;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_read;
  logic              rom_ena;
  logic              ins_valid;
  logic              ins_ready;
  logic [DATA_W-1:0] ins_opcode;
  logic [DATA_W-1:0] ins_operand;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_addr;
  logic              halted;
  logic [ADDR_W-1:0] pc;

  modport master (
    input  rom_data, ins_ready, pc_load, pc_load_addr,
    output rom_addr, rom_read, rom_ena, ins_valid, ins_opcode, ins_operand,
           halted, pc
  );

  modport slave (
    output rom_data, ins_ready, pc_load, pc_load_addr,
    input  rom_addr, rom_read, rom_ena, ins_valid, ins_opcode, ins_operand,
           halted, pc
  );
endinterface

// File: rtl/rom_fetch.sv
// Instruction fetch unit: owns the PC, reads one/two-byte instructions from ROM
// and hands them to the decoder. Define ROM_FETCH_JMP_EN to resolve JMP locally.
module rom_fetch #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  rom_fetch_if.master  bus
);
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH_OP  = 3'd1;
  localparam logic [2:0] S_FETCH_ARG = 3'd2;
  localparam logic [2:0] S_ISSUE     = 3'd3;
  localparam logic [2:0] S_HALT      = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] opcode_q, opcode_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic              fetching;

  function automatic logic is_two_byte(input logic [DATA_W-1:0] op);
    case (op[DATA_W-1 -: 4])
      4'h1, 4'h2, 4'h3, 4'hA: is_two_byte = 1'b1;
      default:                is_two_byte = 1'b0;
    endcase
  endfunction

  function automatic logic is_hlt(input logic [DATA_W-1:0] op);
    is_hlt = (op[DATA_W-1 -: 4] == 4'hF);
  endfunction

`ifdef ROM_FETCH_JMP_EN
  function automatic logic is_jmp(input logic [DATA_W-1:0] op);
    is_jmp = (op[DATA_W-1 -: 4] == 4'hA);
  endfunction
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    // Redirect beats everything, including an in-flight or unaccepted instruction.
    if (bus.pc_load) begin
      pc_d    = bus.pc_load_addr;
      state_d = S_FETCH_OP;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_FETCH_OP;
        S_FETCH_OP: begin
          opcode_d = bus.rom_data;
          pc_d     = pc_q + ADDR_W'(1);
          if (is_two_byte(bus.rom_data)) begin
            state_d = S_FETCH_ARG;
          end else begin
            operand_d = '0;
            state_d   = S_ISSUE;
          end
        end
        S_FETCH_ARG: begin
          operand_d = bus.rom_data;
          pc_d      = pc_q + ADDR_W'(1);
          state_d   = S_ISSUE;
`ifdef ROM_FETCH_JMP_EN
          if (is_jmp(opcode_q)) begin
            pc_d    = ADDR_W'(bus.rom_data);
            state_d = S_FETCH_OP;
          end
`endif
        end
        S_ISSUE: begin
          if (bus.ins_ready) state_d = is_hlt(opcode_q) ? S_HALT : S_FETCH_OP;
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      opcode_q  <= '0;
      operand_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
    end
  end

  // ROM strobes only in the two fetch states so the data bus floats otherwise.
  assign fetching        = (state_q == S_FETCH_OP) || (state_q == S_FETCH_ARG);
  assign bus.rom_read    = fetching;
  assign bus.rom_ena     = fetching;
  assign bus.rom_addr    = pc_q;
  assign bus.ins_valid   = (state_q == S_ISSUE);
  assign bus.ins_opcode  = opcode_q;
  assign bus.ins_operand = operand_q;
  assign bus.halted      = (state_q == S_HALT);
  assign bus.pc          = pc_q;
endmodule

// File: tb/tb_rom_fetch.sv
// Directed cycle-by-cycle bench for rom_fetch; expectations follow ROM_FETCH_JMP_EN.
module tb_rom_fetch;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rom_fetch_if #(.ADDR_W(8), .DATA_W(8)) bus();

  logic [7:0] rom [0:255];
  // Undriven bus modelled as zero; the unit only samples it while reading.
  assign bus.rom_data = (bus.rom_read && bus.rom_ena) ? rom[bus.rom_addr] : 8'h00;

  rom_fetch #(.ADDR_W(8), .DATA_W(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rdy;
    logic        ld;
    logic [7:0]  ld_addr;
    logic [35:0] exp;
  } vec_t;

  vec_t vq[$];
  int   tests = 0;
  int   fails = 0;

  // {rom_read, rom_ena, ins_valid, halted, rom_addr, opcode, operand, pc}; pc == rom_addr
  function automatic logic [35:0] mk(input logic rd, input logic v, input logic h,
                                     input logic [7:0] a, input logic [7:0] op,
                                     input logic [7:0] opr);
    return {rd, rd, v, h, a, op, opr, a};
  endfunction

  function automatic logic [35:0] snap();
    return {bus.rom_read, bus.rom_ena, bus.ins_valid, bus.halted, bus.rom_addr,
            bus.ins_opcode, bus.ins_operand, bus.pc};
  endfunction

  task automatic add(input logic rdy, input logic ld, input logic [7:0] la,
                     input logic [35:0] e);
    vec_t v;
    v.rdy = rdy; v.ld = ld; v.ld_addr = la; v.exp = e;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [7:0] hp;
    rst = 1'b1;
    bus.ins_ready = 1'b1;
    bus.pc_load = 1'b0;
    bus.pc_load_addr = 8'h00;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[1] = 8'h11; rom[2] = 8'h81; rom[3] = 8'h45; rom[4] = 8'h22; rom[5] = 8'h33;
    rom[6] = 8'h05; rom[7] = 8'h06; rom[8] = 8'h07; rom[9] = 8'hA3; rom[10] = 8'h0F;
    rom[11] = 8'h0B; rom[12] = 8'h0C; rom[13] = 8'h0D; rom[14] = 8'hF0; rom[15] = 8'hF0;
    rom[255] = 8'h11;

    // NOP, LDO 0x81, one-byte, LDA 0x33 stalled 5 cycles, one-byte
    add(1, 0, 0, mk(0, 0, 0, 8'h00, 8'h00, 8'h00));
    add(1, 0, 0, mk(1, 0, 0, 8'h00, 8'h00, 8'h00));
    add(1, 0, 0, mk(0, 1, 0, 8'h01, 8'h00, 8'h00));
    add(1, 0, 0, mk(1, 0, 0, 8'h01, 8'h00, 8'h00));
    add(1, 0, 0, mk(1, 0, 0, 8'h02, 8'h11, 8'h00));
    add(1, 0, 0, mk(0, 1, 0, 8'h03, 8'h11, 8'h81));
    add(1, 0, 0, mk(1, 0, 0, 8'h03, 8'h11, 8'h81));
    add(1, 0, 0, mk(0, 1, 0, 8'h04, 8'h45, 8'h00));
    add(1, 0, 0, mk(1, 0, 0, 8'h04, 8'h45, 8'h00));
    add(1, 0, 0, mk(1, 0, 0, 8'h05, 8'h22, 8'h00));
    for (int i = 0; i < 5; i++) add(0, 0, 0, mk(0, 1, 0, 8'h06, 8'h22, 8'h33));
    add(1, 0, 0, mk(0, 1, 0, 8'h06, 8'h22, 8'h33));
    add(1, 0, 0, mk(1, 0, 0, 8'h06, 8'h22, 8'h33));
    add(1, 0, 0, mk(0, 1, 0, 8'h07, 8'h05, 8'h00));
    add(1, 0, 0, mk(1, 0, 0, 8'h07, 8'h05, 8'h00));
    add(1, 0, 0, mk(0, 1, 0, 8'h08, 8'h06, 8'h00));
    add(1, 0, 0, mk(1, 0, 0, 8'h08, 8'h06, 8'h00));
    add(1, 0, 0, mk(0, 1, 0, 8'h09, 8'h07, 8'h00));
    // JMP 0x0F at address 9
    add(1, 0, 0, mk(1, 0, 0, 8'h09, 8'h07, 8'h00));
    add(1, 0, 0, mk(1, 0, 0, 8'h0A, 8'hA3, 8'h00));
`ifdef ROM_FETCH_JMP_EN
    add(1, 0, 0, mk(1, 0, 0, 8'h0F, 8'hA3, 8'h0F));
    add(1, 0, 0, mk(0, 1, 0, 8'h10, 8'hF0, 8'h00));
    hp = 8'h10;
`else
    add(1, 0, 0, mk(0, 1, 0, 8'h0B, 8'hA3, 8'h0F));
    add(1, 0, 0, mk(1, 0, 0, 8'h0B, 8'hA3, 8'h0F));
    add(1, 0, 0, mk(0, 1, 0, 8'h0C, 8'h0B, 8'h00));
    add(1, 0, 0, mk(1, 0, 0, 8'h0C, 8'h0B, 8'h00));
    add(1, 0, 0, mk(0, 1, 0, 8'h0D, 8'h0C, 8'h00));
    add(1, 0, 0, mk(1, 0, 0, 8'h0D, 8'h0C, 8'h00));
    add(1, 0, 0, mk(0, 1, 0, 8'h0E, 8'h0D, 8'h00));
    add(1, 0, 0, mk(1, 0, 0, 8'h0E, 8'h0D, 8'h00));
    add(1, 0, 0, mk(0, 1, 0, 8'h0F, 8'hF0, 8'h00));
    hp = 8'h0F;
`endif
    // HLT parks the unit until a redirect
    for (int i = 0; i < 11; i++) add(1, 0, 0, mk(0, 0, 1, hp, 8'hF0, 8'h00));
    add(1, 1, 8'h20, mk(0, 0, 1, hp, 8'hF0, 8'h00));
    add(1, 1, 8'hFF, mk(1, 0, 0, 8'h20, 8'hF0, 8'h00));
    // two-byte fetch across the 255 -> 0 wrap
    add(1, 0, 0, mk(1, 0, 0, 8'hFF, 8'hF0, 8'h00));
    add(1, 0, 0, mk(1, 0, 0, 8'h00, 8'h11, 8'h00));
    // redirect in the same cycle as an accepted issue
    add(1, 1, 8'h03, mk(0, 1, 0, 8'h01, 8'h11, 8'h00));
    add(1, 0, 0, mk(1, 0, 0, 8'h03, 8'h11, 8'h00));
    // redirect drops a stalled, unaccepted instruction
    add(0, 0, 0, mk(0, 1, 0, 8'h04, 8'h45, 8'h00));
    add(0, 1, 8'h01, mk(0, 1, 0, 8'h04, 8'h45, 8'h00));
    add(1, 0, 0, mk(1, 0, 0, 8'h01, 8'h45, 8'h00));

    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset", snap(), mk(0, 0, 0, 8'h00, 8'h00, 8'h00));
    rst = 1'b1;
    foreach (vq[i]) begin
      bus.ins_ready    = vq[i].rdy;
      bus.pc_load      = vq[i].ld;
      bus.pc_load_addr = vq[i].ld_addr;
      #1 chk($sformatf("vec%0d", i), snap(), vq[i].exp);
      @(negedge clk);
    end
    bus.ins_ready = 1'b1;
    bus.pc_load   = 1'b0;

    // asynchronous reset in the middle of an operand fetch
    chk("fetch_arg_pre_reset", snap(), mk(1, 0, 0, 8'h02, 8'h11, 8'h00));
    #2 rst = 1'b0;
    #1 chk("async_reset", snap(), mk(0, 0, 0, 8'h00, 8'h00, 8'h00));
    @(negedge clk);
    chk("held_in_reset", snap(), mk(0, 0, 0, 8'h00, 8'h00, 8'h00));
    rst = 1'b1;
    @(negedge clk);
    chk("restart_fetch", snap(), mk(1, 0, 0, 8'h00, 8'h00, 8'h00));
    @(negedge clk);
    chk("restart_issue", snap(), mk(0, 1, 0, 8'h01, 8'h00, 8'h00));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rom_fetch.md
# rom_fetch

Instruction fetch unit that initiates reads to the program ROM and hands complete instructions to the decoder. Owns the program counter, drives the ROM `addr`/`read`/`ena` pins, assembles one- and two-byte instructions, and resolves `JMP` locally. Sits between the program ROM and the CPU decoder/controller.

## Interface
Parameters:
- `ADDR_W`, 8: program counter and ROM address width.
- `DATA_W`, 8: instruction byte width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `rom_data`  in  8  ROM read data; combinational from `rom_addr` while `rom_read && rom_ena`, otherwise Z.
- `rom_addr`  out  8  ROM address (the current PC).
- `rom_read`  out  1  ROM read strobe.
- `rom_ena`  out  1  ROM enable.
- `ins_valid`  out  1  instruction on `ins_opcode`/`ins_operand` is valid.
- `ins_ready`  in  1  decoder accepts the instruction.
- `ins_opcode`  out  8  first instruction byte.
- `ins_operand`  out  8  second byte for two-byte instructions, 0 otherwise.
- `pc_load`  in  1  external PC redirect request.
- `pc_load_addr`  in  8  redirect target.
- `halted`  out  1  `HLT` has been issued and fetching has stopped.
- `pc`  out  8  current program counter.

## Operation
- Instruction class comes from the opcode high nibble:
  - Two-byte: `0001` LDO, `0010` LDA, `0011` STO, `1010` JMP.
  - One-byte: all other opcodes.
  - `1111` is HLT.
- FSM states: `IDLE`, `FETCH_OP`, `FETCH_ARG`, `ISSUE`, `HALT`.
- `IDLE` (reset state): go to `FETCH_OP` on the next cycle.
- `FETCH_OP`:
  - `rom_read = rom_ena = 1`, `rom_addr = pc`.
  - On the clock edge, register `rom_data` into `ins_opcode` and set `pc <= pc+1`.
  - Two-byte opcode: go to `FETCH_ARG`. Otherwise set `ins_operand <= 0` and go to `ISSUE`.
- `FETCH_ARG`:
  - Same ROM drive as `FETCH_OP`. Register `rom_data` into `ins_operand` and set `pc <= pc+1`.
  - JMP with `ROM_FETCH_JMP_EN` defined: set `pc <= rom_data` and go to `FETCH_OP`; JMP is not issued.
  - Otherwise go to `ISSUE`.
- `ISSUE`:
  - `ins_valid = 1`, and `ins_opcode`/`ins_operand` are held stable until `ins_valid && ins_ready` at an edge.
  - On acceptance: HLT goes to `HALT` and sets `halted`; any other opcode goes to `FETCH_OP`.
- `HALT`: `rom_read = rom_ena = 0`. Stays here until `pc_load` or reset.
- `rom_read`/`rom_ena` are 0 in `IDLE`, `ISSUE` and `HALT`, so the ROM data bus is floated.
- PC arithmetic is modulo 256: 255+1 wraps to 0. This also applies to an operand fetch at address 255, which reads address 0.
- `pc_load` has the highest priority in every state:
  - Sets `pc <= pc_load_addr`, clears `ins_valid` and `halted`, and goes to `FETCH_OP`.
  - A pending unaccepted instruction is dropped.
  - A `pc_load` in the same cycle as an `ISSUE` handshake: the handshake completes for the decoder, and the fetch unit still redirects.
- Reset mid-operation: returns immediately to `IDLE` with all reset values; any in-flight instruction is discarded.

## Timing
- Reset values: `rom_addr=0`, `rom_read=0`, `rom_ena=0`, `ins_valid=0`, `ins_opcode=0`, `ins_operand=0`, `halted=0`, `pc=0`, state `IDLE`.
- First ROM read is 1 cycle after reset release; the first `ins_valid` is 1 cycle later for a one-byte instruction, 2 cycles later for a two-byte one.
- With `ins_ready` tied high:
  - One-byte instruction: 2 cycles (`FETCH_OP`, `ISSUE`).
  - Two-byte instruction: 3 cycles.
  - Internally resolved JMP: 2 cycles, nothing issued.
- `ins_ready` low stalls the unit indefinitely in `ISSUE`; no ROM access occurs while stalled.
- `pc_load` takes effect at the edge; the ROM read of `pc_load_addr` happens in the following cycle.

## Configuration
- `ROM_FETCH_JMP_EN` defined: JMP (`1010xxxx`) is resolved inside the fetch unit and never presented on `ins_*`.
- Not defined: JMP is issued as an ordinary two-byte instruction and the PC continues sequentially. The controller must redirect the fetch unit via `pc_load`.

## Test plan
- ROM[0]=0x00 (NOP), `ins_ready=1`, after reset release → `rom_addr=0` read at cycle 1; `ins_valid` at cycle 2 with opcode 0x00 and operand 0x00; `pc=1`.
- ROM[1]=0x11, ROM[2]=0x81 → `ins_valid` with opcode 0x11 and operand 0x81; `pc=3`; `rom_read` low during `ISSUE`.
- With `ROM_FETCH_JMP_EN`, ROM[9]=0xA3, ROM[10]=0x0F → no `ins_valid` for the JMP; next ROM read at address 15. Without the macro → opcode 0xA3 and operand 0x0F issued, next read at address 11.
- Hold `ins_ready=0` for 5 cycles during `ISSUE` → opcode/operand stable, `rom_ena=0` throughout; accepted on the first cycle `ins_ready=1`.
- ROM[14]=0xF0 accepted → `halted=1`, `rom_read=rom_ena=0` for 10+ cycles. Then `pc_load=1` with `pc_load_addr=0x20` → `halted=0`, next read at address 0x20.
- `pc=255` fetching 0x11 → operand read from address 0 and `pc=1` afterwards. Assert `rst` low during `FETCH_ARG` → all outputs return to reset values asynchronously.
